// File: rtl/score_bcd_keeper.sv
// score_bcd_keeper: running game score held as packed BCD digits, fed one unit
// per clock from a pending-units counter, and latched once per frame into the
// ASCII digit codes for the "SCORE:" text field.
// Optional build macro SCORE_HISCORE_EN adds a BCD high-score register and
// its latched ASCII output hiscore_char.
module score_bcd_keeper #(
    parameter int DIGITS = 3,
    parameter int PEND_W = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic                  clear,
    input  logic                  add_valid,
    input  logic [PEND_W-1:0]     add_units,
    output logic [8*DIGITS-1:0]   score_char,
    output logic                  busy,
    output logic                  saturated
`ifdef SCORE_HISCORE_EN
    ,
    output logic [8*DIGITS-1:0]   hiscore_char
`endif
);

    logic [4*DIGITS-1:0] digits;
    logic [4*DIGITS-1:0] digits_inc;
    logic                all_nines;
    logic [PEND_W-1:0]   pending;
    logic [PEND_W-1:0]   pending_next;
    logic                dec;
    logic                fs1, fs2, fs3;
    logic                frame_tick;

    // BCD digit d maps to ASCII 8'h30 + d, i.e. upper nibble 3, lower nibble d
    function automatic logic [8*DIGITS-1:0] to_ascii(input logic [4*DIGITS-1:0] d);
        logic [8*DIGITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[8*i +: 8] = {4'h3, d[4*i +: 4]};
        end
        return r;
    endfunction

    // Frame signal synchroniser plus registered rising-edge detector
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs1        <= 1'b0;
            fs2        <= 1'b0;
            fs3        <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            fs1        <= frame_clk;
            fs2        <= fs1;
            fs3        <= fs2;
            frame_tick <= fs2 & ~fs3;
        end
    end

    // One-unit BCD increment with the carry rippling through every digit
    always_comb begin
        logic carry;
        digits_inc = digits;
        all_nines  = 1'b1;
        carry      = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (digits[4*i +: 4] == 4'd9) begin
                    digits_inc[4*i +: 4] = 4'd0;
                end else begin
                    digits_inc[4*i +: 4] = digits[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

    // Pending-units next state: clear beats add, add saturates at all ones
    always_comb begin
        logic [PEND_W:0] sum;
        dec = (pending != '0) && !clear;
        sum = {1'b0, pending} + {1'b0, add_units} - {{PEND_W{1'b0}}, dec};
        if (clear) begin
            pending_next = '0;
        end else if (add_valid) begin
            pending_next = sum[PEND_W] ? '1 : sum[PEND_W-1:0];
        end else begin
            pending_next = pending - {{(PEND_W-1){1'b0}}, dec};
        end
    end

    // Score digits, pending counter, status flags and the per-frame display latch
    always_ff @(posedge Clk) begin
        if (Reset) begin
            digits     <= '0;
            pending    <= '0;
            busy       <= 1'b0;
            saturated  <= 1'b0;
            score_char <= {DIGITS{8'h30}};
        end else begin
            pending <= pending_next;
            busy    <= (pending_next != '0);
            if (clear) begin
                digits    <= '0;
                saturated <= 1'b0;
            end else if (dec) begin
                if (all_nines) begin
                    saturated <= 1'b1;
                end else begin
                    digits <= digits_inc;
                end
            end
            // Latches the pre-increment value when a tick and an increment coincide
            if (frame_tick) begin
                score_char <= to_ascii(digits);
            end
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [4*DIGITS-1:0] hiscore;

    // BCD magnitude compare, most significant digit decides first
    function automatic logic bcd_gt(input logic [4*DIGITS-1:0] a, input logic [4*DIGITS-1:0] b);
        logic decided;
        logic gt;
        int unsigned idx;
        decided = 1'b0;
        gt      = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            idx = DIGITS - 1 - k;
            if (!decided && (a[4*idx +: 4] != b[4*idx +: 4])) begin
                decided = 1'b1;
                gt      = (a[4*idx +: 4] > b[4*idx +: 4]);
            end
        end
        return gt;
    endfunction

    // High score captured at game clear, displayed with the same frame latch
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hiscore      <= '0;
            hiscore_char <= {DIGITS{8'h30}};
        end else begin
            if (clear && bcd_gt(digits, hiscore)) begin
                hiscore <= digits;
            end
            if (frame_tick) begin
                hiscore_char <= to_ascii(hiscore);
            end
        end
    end
`endif

endmodule

// File: tb/tb_score_bcd_keeper.sv
// tb_score_bcd_keeper: directed stimulus with hand-computed expectations pushed
// into a scoreboard queue; a negedge monitor pops and compares against the DUT.
`timescale 1ns/1ps
module tb_score_bcd_keeper;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        clear;
    logic        add_valid;
    logic [7:0]  add_units;
    logic [23:0] score_char;
    logic        busy;
    logic        saturated;
`ifdef SCORE_HISCORE_EN
    logic [23:0] hiscore_char;
`endif

    int checks = 0;
    int errors = 0;

    localparam int K_CHAR = 0;
    localparam int K_BUSY = 1;
    localparam int K_SAT  = 2;
    localparam int K_HI   = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [23:0] val;
    } exp_t;

    exp_t q[$];

    score_bcd_keeper #(.DIGITS(3), .PEND_W(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .clear      (clear),
        .add_valid  (add_valid),
        .add_units  (add_units),
        .score_char (score_char),
        .busy       (busy),
        .saturated  (saturated)
`ifdef SCORE_HISCORE_EN
        ,
        .hiscore_char (hiscore_char)
`endif
    );

    always #5 Clk = ~Clk;

    // Monitor: every queued expectation refers to the state after the last rising edge
    always @(negedge Clk) begin
        exp_t        e;
        logic [23:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_CHAR:  act = score_char;
                K_BUSY:  act = {23'd0, busy};
                K_SAT:   act = {23'd0, saturated};
`ifdef SCORE_HISCORE_EN
                K_HI:    act = hiscore_char;
`endif
                default: act = 'x;
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_v(input string name, input int kind, input logic [23:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic expect_hi(input string name, input logic [23:0] val);
`ifdef SCORE_HISCORE_EN
        expect_v(name, K_HI, val);
`endif
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        repeat (6) step();
        frame_clk = 1'b0;
        repeat (4) step();
    endtask

    task automatic add_n(input logic [7:0] n);
        add_valid = 1'b1;
        add_units = n;
        step();
        add_valid = 1'b0;
        add_units = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        clear     = 1'b0;
        add_valid = 1'b0;
        add_units = '0;
        repeat (3) step();
        Reset = 1'b0;
        expect_v("rst_char", K_CHAR, 24'h303030);
        expect_v("rst_busy", K_BUSY, 24'd0);
        expect_v("rst_sat",  K_SAT,  24'd0);
        expect_hi("rst_hi", 24'h303030);
        frame();
        expect_v("rst_frame_char", K_CHAR, 24'h303030);
        expect_v("rst_frame_busy", K_BUSY, 24'd0);
        expect_v("rst_frame_sat",  K_SAT,  24'd0);

        // three units: busy for exactly three cycles after the add edge
        add_n(8'd3);
        expect_v("add3_busy_t1", K_BUSY, 24'd1);
        step(); expect_v("add3_busy_t2", K_BUSY, 24'd1);
        step(); expect_v("add3_busy_t3", K_BUSY, 24'd1);
        step(); expect_v("add3_busy_t4", K_BUSY, 24'd0);
        frame();
        expect_v("add3_char", K_CHAR, 24'h303033);

        // reach 042, clear: high score captures it
        add_n(8'd39); wait_idle("to42");
        do_clear();
        frame();
        expect_v("clr42_char", K_CHAR, 24'h303030);
        expect_hi("hi_042", 24'h303432);
        // reach 010, clear: high score unchanged
        add_n(8'd10); wait_idle("to10");
        do_clear();
        frame();
        expect_v("clr10_char", K_CHAR, 24'h303030);
        expect_hi("hi_keep_042", 24'h303432);

        // carry chains 009 -> 010 and 099 -> 100
        add_n(8'd9); wait_idle("to9"); frame();
        expect_v("char_009", K_CHAR, 24'h303039);
        add_n(8'd1); wait_idle("to10b"); frame();
        expect_v("char_010", K_CHAR, 24'h303130);
        add_n(8'd89); wait_idle("to99"); frame();
        expect_v("char_099", K_CHAR, 24'h303939);
        add_n(8'd1); wait_idle("to100"); frame();
        expect_v("char_100", K_CHAR, 24'h313030);

        // 100 + 898 = 998
        add_n(8'd255); wait_idle("to355");
        add_n(8'd255); wait_idle("to610");
        add_n(8'd255); wait_idle("to865");
        add_n(8'd133); wait_idle("to998");
        frame();
        expect_v("char_998", K_CHAR, 24'h393938);
        expect_v("sat_998",  K_SAT,  24'd0);

        // 998 + 5: holds at 999, pending still drains in five cycles
        add_n(8'd5);
        expect_v("sat_busy_0", K_BUSY, 24'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_v($sformatf("sat_busy_%0d", i), K_BUSY, (i < 5) ? 24'd1 : 24'd0);
        end
        expect_v("sat_set", K_SAT, 24'd1);
        frame();
        expect_v("char_999", K_CHAR, 24'h393939);
        expect_v("sat_sticky", K_SAT, 24'd1);

        // clear: saturated drops at once, display waits for the next frame
        do_clear();
        expect_v("clr_sat",  K_SAT,  24'd0);
        expect_v("clr_busy", K_BUSY, 24'd0);
        expect_v("clr_char_hold", K_CHAR, 24'h393939);
        frame();
        expect_v("clr_char_frame", K_CHAR, 24'h303030);

        // pending 250 + 10 - 1 saturates at 255: 1 + 255 increments = 256
        add_valid = 1'b1;
        add_units = 8'd250;
        step();
        add_units = 8'd10;
        step();
        add_valid = 1'b0;
        add_units = '0;
        expect_v("psat_busy_0", K_BUSY, 24'd1);
        for (int i = 1; i <= 255; i++) begin
            step();
            if (i >= 253) begin
                expect_v($sformatf("psat_busy_%0d", i), K_BUSY, (i < 255) ? 24'd1 : 24'd0);
            end
        end
        frame();
        expect_v("char_256", K_CHAR, 24'h323536);

        // clear together with add_valid: clear wins, pending abandoned
        add_n(8'd20);
        step();
        step();
        clear     = 1'b1;
        add_valid = 1'b1;
        add_units = 8'd7;
        step();
        clear     = 1'b0;
        add_valid = 1'b0;
        add_units = '0;
        expect_v("clradd_busy", K_BUSY, 24'd0);
        expect_v("clradd_sat",  K_SAT,  24'd0);
        expect_v("clradd_char_hold", K_CHAR, 24'h323536);
        step();
        step();
        expect_v("clradd_busy_later", K_BUSY, 24'd0);
        expect_v("clradd_char_later", K_CHAR, 24'h323536);
        frame();
        expect_v("clradd_char_frame", K_CHAR, 24'h303030);
        expect_hi("hi_999", 24'h393939);
        add_n(8'd1); wait_idle("to1"); frame();
        expect_v("char_001", K_CHAR, 24'h303031);

        repeat (2) step();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_bcd_keeper.md
Name: score_bcd_keeper

Overview:
- Holds the running game score as packed BCD digits and produces the ASCII character codes for the changing digit cells of the on-screen "SCORE:" field.
- Sits directly upstream of the score-text address generator, which turns each code into a font ROM row address (code*16 + row).
- Score events arrive as unit counts and are applied one unit per clock through a pending-units counter.
- Displayed digits are latched once per frame so a frame never shows a half-updated score.

Parameters:
- DIGITS, 3, number of BCD score digits (the field's fixed trailing zeros are not part of this block).
- PEND_W, 8, width of the pending-units counter.

Ports:
- Clk  input  1  system clock; all logic is synchronous to the rising edge.
- Reset  input  1  synchronous, active-high reset.
- frame_clk  input  1  vertical-sync-rate frame signal, asynchronous to Clk; its rising edge marks a frame boundary.
- clear  input  1  single-cycle pulse that starts a new game and zeroes the score.
- add_valid  input  1  single-cycle strobe that qualifies add_units.
- add_units  input  PEND_W  number of score units to add.
- score_char  output  8*DIGITS  latched ASCII digit codes; bits [7:0] hold the least significant digit.
- busy  output  1  high while the pending count is nonzero.
- saturated  output  1  sticky; set when the score has reached its maximum value (all 9s).

Behaviour:
- Reset, sampled at a Clk edge, sets:
  - all internal BCD digits to 0, pending to 0, saturated to 0;
  - every byte of score_char to 8'h30;
  - the frame synchroniser flops to 0.
- frame_clk passes through a 2-flop synchroniser followed by a registered rising-edge detector; this produces frame_tick, one Clk cycle wide.
- Pending update, evaluated each cycle in priority order:
  - clear: pending <= 0.
  - add_valid: pending <= pending + add_units - dec, saturating at 2^PEND_W-1.
  - otherwise: pending <= pending - dec.
  - dec = 1 when pending != 0 and clear is low.
- Score update:
  - In any cycle where dec = 1, the BCD score increments by one unit. The LSD rolls 9->0 with a carry, and the carry ripples through all digits within the same cycle.
  - If every digit is already 9, the increment is discarded. pending still decrements, and saturated is set.
- Latency: add_valid with N units at cycle t gives score increments at edges t+1 through t+N, provided no clear and no saturation intervene.
- Display latch: on frame_tick, each digit d is loaded into score_char as 8'h30 + d, using the score value at that edge.
  - If frame_tick and an increment occur in the same cycle, the pre-increment value is latched.
- clear:
  - zeroes the digits and saturated in the same edge;
  - drops any add_valid in the same cycle (clear wins);
  - leaves score_char unchanged until the next frame_tick.
- busy = (pending != 0), registered.
- Reset or clear asserted while pending is nonzero abandons the remaining units.
- score_char and saturated are registered outputs; the block contains no combinational input-to-output path.

Optional Feature:
- Macro SCORE_HISCORE_EN.
- When defined:
  - adds output hiscore_char (8*DIGITS) and an internal BCD high-score register, reset to 0 with hiscore_char = 8'h30 per byte;
  - on clear, if the current score is greater than the high score (BCD magnitude compare, MSD first), the high score takes the current score;
  - hiscore_char updates on frame_tick using the same latch rule as score_char.
- When undefined: the port, the register and the compare logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset, then toggle frame_clk -> score_char = 24'h303030, busy = 0, saturated = 0.
- add_units = 3 at cycle t -> busy high for cycles t+1..t+3; after the next frame_tick, score_char = 24'h303033.
- Score at 099, add 1 -> digits become 100; after frame_tick, score_char = 24'h313030. Score at 009 +1 -> 010.
- Score at 998, add 5 -> score holds at 999, saturated = 1, pending drains to 0 in 5 cycles.
- pending = 250, add_valid with 10 -> pending = 255 (saturating). clear asserted together with add_valid -> pending = 0, digits = 000, score_char unchanged until frame_tick.
- With SCORE_HISCORE_EN: reach score 042, clear -> after frame_tick, hiscore_char = 24'h303432. Reach 010, clear -> hiscore_char stays 24'h303432.
